// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: MMIO bridge between the MIPS150 memory stage and the UART (TX FIFO, RX holding register).
// Latency: cpu_rdata valid the cycle after cpu_re; a TXDATA store raises ua_tx_valid two cycles later.
// Backpressure: TX drains on ua_tx_ready; full-FIFO store drops and sets tx_ovf, or stalls with UART_IO_CTRL_STALL_EN.
module uart_io_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [7:0]  cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [7:0]  ua_tx_data,
  output logic        ua_tx_valid,
  input  logic        ua_tx_ready,
  input  logic [7:0]  ua_rx_data,
  input  logic        ua_rx_valid,
  output logic        ua_rx_ready
);

  localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [31:0]      ADDR_STATUS = 32'h8000_0000;
  localparam logic [31:0]      ADDR_RXDATA = 32'h8000_0004;
  localparam logic [31:0]      ADDR_TXDATA = 32'h8000_0008;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(TX_DEPTH);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  tx_state_e        state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rx_full_q, rx_full_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       mem_q [TX_DEPTH];

  logic             sel_status, sel_rx, sel_tx;
  logic             tx_full, push_req, push, pop;
  logic             rx_cap, rx_pop, ovf_set, ovf_clr;
  logic [3:0]       cnt_nib;

  // Full-FIFO policy: stall the pipeline until space frees, or drop and flag overflow.
`ifdef UART_IO_CTRL_STALL_EN
  assign cpu_stall = push_req & tx_full;
  assign ovf_set   = 1'b0;
`else
  assign cpu_stall = 1'b0;
  assign ovf_set   = push_req & tx_full;
`endif

  // Address decode and handshake qualifiers; pop keys off the registered state only.
  always_comb begin
    sel_status = (cpu_addr == ADDR_STATUS);
    sel_rx     = (cpu_addr == ADDR_RXDATA);
    sel_tx     = (cpu_addr == ADDR_TXDATA);
    tx_full    = (count_q == DEPTH_C);
    push_req   = cpu_we & sel_tx;
    push       = push_req & ~tx_full;
    pop        = (state_q == TX_SEND) & ua_tx_ready;
    rx_cap     = ua_rx_valid & ~rx_full_q;
    rx_pop     = cpu_re & sel_rx & rx_full_q;
    ovf_clr    = cpu_we & sel_status & cpu_wdata[2];
    cnt_nib    = 4'(count_q);
  end

  // FIFO pointers, occupancy, sticky overflow and RX holding register next-state.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    tx_ovf_d  = tx_ovf_q;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (ovf_clr) tx_ovf_d = 1'b0;
    if (ovf_set) tx_ovf_d = 1'b1;
    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_byte_d = ua_rx_data;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end
  end

  // Load data: sampled state at the cpu_re cycle, held until the next load.
  always_comb begin
    rdata_d = rdata_q;
    if (cpu_re) begin
      if (sel_status)
        rdata_d = {24'b0, cnt_nib, 1'b0, tx_ovf_q, ~tx_full, rx_full_q};
      else if (sel_rx)
        rdata_d = {24'b0, rx_byte_q};
      else
        rdata_d = 32'b0;
    end
  end

  // TX FSM next-state and UART-side outputs; data is zero outside TX_SEND.
  always_comb begin
    state_d     = state_q;
    ua_tx_valid = 1'b0;
    ua_tx_data  = 8'h00;
    case (state_q)
      TX_IDLE: begin
        if (count_q != '0) state_d = TX_SEND;
      end
      TX_SEND: begin
        ua_tx_valid = 1'b1;
        ua_tx_data  = mem_q[rd_ptr_q];
        if (pop && (count_d == '0)) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign ua_rx_ready = ~rx_full_q;
  assign cpu_rdata   = rdata_q;

  // Control state; reset drops FIFO occupancy and any held RX byte immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tx_ovf_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_byte_q <= 8'h00;
      rdata_q   <= 32'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      rdata_q   <= rdata_d;
    end
  end

  // FIFO storage; contents are only observable through count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpu_wdata;
  end

endmodule
